// File: rtl/shift_arbiter_pkg.sv
// Shared ALU constants: op encodings and default datapath widths.
package shift_arbiter_pkg;

  localparam int unsigned DATA_W_DEFAULT  = 32;
  localparam int unsigned SHAMT_W_DEFAULT = 5;

  typedef enum logic {
    OP_SLL = 1'b0,
    OP_SRA = 1'b1
  } shift_op_e;

endpackage : shift_arbiter_pkg

// File: rtl/shift_arbiter_shift_core.sv
// Combinational log-stage barrel shifter covering SLL and SRA.
module shift_core
  import shift_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned SHAMT_W = SHAMT_W_DEFAULT
) (
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               op,
  output logic [DATA_W-1:0]  result
);

  logic              sign;
  logic [DATA_W-1:0] stage [0:SHAMT_W];

  assign sign     = data[DATA_W-1];
  assign stage[0] = data;

  // Stage s shifts by 2**s when shamt[s] is set; SRA fills with the original sign bit.
  for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
    localparam int unsigned AMT = 1 << s;
    logic [DATA_W-1:0] shifted;

    // Select the fixed-distance shift for this stage.
    always_comb begin
      if (op == OP_SRA) begin
        shifted = {{AMT{sign}}, stage[s][DATA_W-1:AMT]};
      end else begin
        shifted = {stage[s][DATA_W-1-AMT:0], {AMT{1'b0}}};
      end
    end

    assign stage[s+1] = shamt[s] ? shifted : stage[s];
  end

  assign result = stage[SHAMT_W];

endmodule : shift_core

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of a shared shifter with a
// single registered result slot.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned SHAMT_W = SHAMT_W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic               req1_op,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DATA_W-1:0]  resp_data,
  output logic               resp_id
);

  logic               prio;
  logic               grant;
  logic               slot_free;
  logic               accept;
  logic [DATA_W-1:0]  sel_data;
  logic [SHAMT_W-1:0] sel_shamt;
  logic               sel_op;
  logic [DATA_W-1:0]  shift_result;

  assign slot_free = !resp_valid || resp_ready;

  // Grant: sole valid requester wins; on contention the priority pointer decides.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = prio;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Readys depend only on valids, prio and the result slot, never on datapath values.
  always_comb begin
    req0_ready = !reset && slot_free && req0_valid && (grant == 1'b0);
    req1_ready = !reset && slot_free && req1_valid && (grant == 1'b1);
    accept     = req0_ready || req1_ready;
  end

  // Steer the granted requester's operands into the shared shifter.
  always_comb begin
    sel_data  = grant ? req1_data  : req0_data;
    sel_shamt = grant ? req1_shamt : req0_shamt;
    sel_op    = grant ? req1_op    : req0_op;
  end

  shift_core #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_shift_core (
    .data   (sel_data),
    .shamt  (sel_shamt),
    .op     (sel_op),
    .result (shift_result)
  );

  // Result register and priority pointer; a new acceptance overrides a drain.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
      prio       <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_data  <= shift_result;
      resp_id    <= grant;
      prio       <= ~grant;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule : shift_arbiter

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand and result width in bits.
REQ-002 Parameter SHAMT_W, default 5, shift-amount width; SHALL equal log2(DATA_W).
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 offers an operation.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 req0_data  input  DATA_W  requester 0 operand.
REQ-008 req0_shamt  input  SHAMT_W  requester 0 shift amount.
REQ-009 req0_op  input  1  requester 0 op: 0 = SLL, 1 = SRA.
REQ-010 req1_valid, req1_ready, req1_data, req1_shamt, req1_op  same directions, widths and meanings as REQ-005..009, for requester 1.
REQ-011 resp_valid  output  1  result register holds a result.
REQ-012 resp_ready  input  1  consumer takes the result this cycle.
REQ-013 resp_data  output  DATA_W  shifted result.
REQ-014 resp_id  output  1  index of the requester that owns resp_data.

Function
REQ-015 An operation is accepted on a cycle where reqN_valid and reqN_ready are both 1.
REQ-016 slot_free = !resp_valid || resp_ready, evaluated combinationally.
REQ-017 reqN_ready SHALL be 1 only when slot_free is 1, reqN_valid is 1 and requester N holds the grant. At most one ready is 1 per cycle.
REQ-018 Grant with one valid requester: that requester. Grant with both valid: the requester selected by the priority pointer prio (0 or 1).
REQ-019 After every accepted operation, prio SHALL become the index of the requester that was not granted. prio is unchanged on cycles with no acceptance.
REQ-020 Latency is 1 cycle: an operation accepted in cycle T SHALL appear on resp_valid, resp_data and resp_id in cycle T+1.
REQ-021 SLL: result = operand << shamt, zero fill. SRA: result = operand >>> shamt, filled with operand bit DATA_W-1. shamt = 0 returns the operand unchanged; shamt = DATA_W-1 with SRA returns all copies of the sign bit.
REQ-022 While resp_valid = 1 and resp_ready = 0, resp_data and resp_id SHALL hold, and both reqN_ready SHALL be 0 (backpressure).
REQ-023 When resp_ready = 1 and a new acceptance happen in the same cycle, the result register SHALL load the new result. resp_valid stays 1, with no bubble.
REQ-024 When resp_ready = 1 and there is no acceptance, resp_valid SHALL clear next cycle. resp_data may hold its stale value.
REQ-025 Requesters are required to hold their valid and payload stable until ready. The block does not check this.
REQ-026 The block contains no combinational path from resp_data to any reqN_ready. reqN_ready depends only on the req valids, prio, resp_valid and resp_ready.

Reset
REQ-027 While reset = 1 at a clock edge: resp_valid = 0, resp_data = 0, resp_id = 0, prio = 0.
REQ-028 While reset = 1, both reqN_ready SHALL be 0.
REQ-029 Reset during a pending result SHALL discard that result without it ever being presented again.

Structure
REQ-030 The op encodings (OP_SLL = 0, OP_SRA = 1) and the default widths SHALL live in the shared ALU constants package, not in this module.
REQ-031 The block SHALL instantiate one combinational sub-module, shift_core (data, shamt, op -> result). shift_core is a log-stage mux barrel shifter covering both SLL and SRA. It is the only shifter in the block.
REQ-032 The arbitration/prio logic and the single result register SHALL be local to shift_arbiter.

Verification
REQ-033 After reset, req0 operand 0xFFFE7938 (-100040), op SRA, shamt 4, resp_ready = 1 -> next cycle resp_valid = 1, resp_data = 0xFFFFE793, resp_id = 0.
REQ-034 Both requesters valid for 4 cycles, resp_ready = 1, with req0 1234 SLL 3 and req1 0x80000000 SRA 31 -> resp_id sequence 0,1,0,1. Results are 9872 and 0xFFFFFFFF respectively.
REQ-035 resp_ready = 0 for 3 cycles with both requesters valid -> one result holds stable and both readys are 0. The first cycle after resp_ready returns to 1 accepts the requester indicated by prio, with no bubble.
REQ-036 Sweep shamt 0..31 for SLL and SRA on operands 0xFFFE7938 and 0x000004D2 -> every resp_data matches the reference shift.
REQ-037 Assert reset while resp_valid = 1 -> next cycle resp_valid = 0, resp_data = 0, prio = 0. The first post-reset contention is granted to req0.
